// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues req/ack accesses, stalls the pipeline
// while an access is outstanding, and feeds the MEM/WB latch with data or a bubble.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWriteEn,
  input  logic [1:0]  control_wb_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] writeData_in,
  input  logic [4:0]  writeReg_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [1:0]  control_wb_out,
  output logic [31:0] readData_out,
  output logic [31:0] alu_out,
  output logic [4:0]  writeReg_out,
  output logic        err_misalign,
  output logic        err_timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic        aborted;
  logic [31:0] rdata_q;
  logic        acc;
  logic        aligned;

  assign acc     = memRead | memWriteEn;
  assign aligned = (alu_in[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      rdata_q      <= '0;
      cnt          <= '0;
      aborted      <= 1'b0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (acc) begin
            if (!aligned) begin
              err_misalign <= 1'b1;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= memWriteEn;
              mem_addr  <= alu_in;
              mem_wdata <= writeData_in;
              cnt       <= '0;
              aborted   <= 1'b0;
              state     <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          // An ack in the final allowed cycle still completes the access.
          if (mem_ack) begin
            if (!mem_we) rdata_q <= mem_rdata;
            mem_req <= 1'b0;
            state   <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            mem_req     <= 1'b0;
            err_timeout <= 1'b1;
            aborted     <= 1'b1;
            state       <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall          = 1'b0;
    control_wb_out = '0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (!acc)         control_wb_out = control_wb_in;
          else if (aligned) stall = 1'b1;
        end
        S_BUSY: stall = 1'b1;
        S_DONE: if (!aborted) control_wb_out = control_wb_in;
        default: ;
      endcase
    end
  end

  assign readData_out = rdata_q;
  assign alu_out      = alu_in;
  assign writeReg_out = writeReg_in;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences data-memory accesses for the MEM stage of the 5-stage MIPS pipeline.
- Sits between the EX/MEM pipeline register, a multi-cycle data memory using a req/ack handshake, and the MEM/WB latch.
- Drives the memory request, freezes upstream stages while an access is outstanding, and presents either valid write-back data or a bubble to the MEM/WB latch.
- Flags misaligned and timed-out accesses.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles in BUSY without mem_ack before abort (range 2..255).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- memRead  in  1  EX/MEM: instruction is a load
- memWriteEn  in  1  EX/MEM: instruction is a store
- control_wb_in  in  2  EX/MEM write-back control {RegWrite, MemtoReg}
- alu_in  in  32  EX/MEM ALU result, also the memory address
- writeData_in  in  32  EX/MEM store data
- writeReg_in  in  5  EX/MEM destination register
- mem_req  out  1  request to data memory (registered)
- mem_we  out  1  1 = write, 0 = read (registered)
- mem_addr  out  32  registered word address
- mem_wdata  out  32  registered store data
- mem_ack  in  1  memory completion, single-cycle pulse
- mem_rdata  in  32  load data, valid with mem_ack
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM registers
- control_wb_out  out  2  to MEM/WB latch; 2'b00 = bubble
- readData_out  out  32  to MEM/WB latch
- alu_out  out  32  to MEM/WB latch
- writeReg_out  out  5  to MEM/WB latch
- err_misalign  out  1  sticky, misaligned access seen
- err_timeout  out  1  sticky, access aborted by timeout

Behaviour:
- Reset: on rst high at posedge, the following are all cleared:
  - state goes to IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, captured data register rdata_q and the timeout counter are cleared.
  - err_misalign and err_timeout are cleared.
  - Applies mid-access too: an outstanding request is dropped and a late mem_ack is ignored.
- While rst is high, stall=0 and control_wb_out=0.
- acc = memRead | memWriteEn. If both are set, the access is treated as a write.
- State IDLE:
  - acc=0: pass-through. control_wb_out=control_wb_in, alu_out=alu_in, writeReg_out=writeReg_in, readData_out=rdata_q, stall=0. Zero added latency.
  - acc=1 with alu_in[1:0]!=0: misaligned. No request is issued. err_misalign is set at the next edge. control_wb_out=0 (bubble), stall=0, state stays IDLE.
  - acc=1 and aligned: stall=1 and control_wb_out=0 (combinational). At the edge, register mem_req=1, mem_we=memWriteEn, mem_addr=alu_in, mem_wdata=writeData_in, clear the counter, and go to BUSY.
- State BUSY:
  - stall=1 and control_wb_out=0.
  - mem_ack=1: at the edge, rdata_q<=mem_rdata (loads only; stores leave rdata_q unchanged), mem_req<=0, go to DONE.
  - No ack: the counter increments. When counter==TIMEOUT_CYCLES-1 with no ack, mem_req<=0, err_timeout<=1, and the access goes to DONE marked aborted.
  - mem_ack and the timeout arriving in the same cycle: ack wins, no error.
- State DONE:
  - Lasts 1 cycle, with stall=0.
  - The EX/MEM inputs are still the held instruction.
  - Completed access: control_wb_out=control_wb_in, readData_out=rdata_q (mem_rdata captured for loads), alu_out, writeReg_out passed through.
  - Aborted access: control_wb_out=0.
  - Next state is IDLE.
- Access latency: a load with an ack k cycles after mem_req rises holds the pipeline for k+1 cycles. The MEM/WB latch captures the data on the DONE edge.
- mem_ack seen in IDLE or DONE is ignored.
- mem_req is held high continuously in BUSY. mem_addr, mem_we and mem_wdata are stable while mem_req=1.
- Back-to-back accesses: DONE always returns to IDLE, so a following access is issued one cycle after DONE.
- Sticky errors clear only on rst.

Test Plan:
- ALU op (acc=0, control_wb_in=2'b10, alu_in=32'h0000_0040) -> stall=0, control_wb_out=2'b10, alu_out=32'h40 in the same cycle.
- Load at addr 32'h100, ack 3 cycles after mem_req, mem_rdata=32'hDEAD_BEEF -> mem_addr=32'h100, mem_we=0, stall high 4 cycles, DONE shows readData_out=32'hDEADBEEF and control_wb_out=2'b11.
- Store at 32'h104 with data 32'h1234_5678, ack after 1 cycle -> mem_we=1, mem_wdata=32'h12345678, stall high 2 cycles, rdata_q unchanged.
- Load at 32'h102 -> no mem_req, control_wb_out=0, err_misalign=1 from the next cycle and it stays set.
- TIMEOUT_CYCLES=4 with no ack -> mem_req drops after 4 BUSY cycles, err_timeout=1, DONE gives control_wb_out=0, back to IDLE. Repeat with ack on the 4th cycle -> no error.
- rst asserted in BUSY cycle 2, then ack next cycle -> state IDLE, mem_req=0, stall=0, errors 0, ack ignored.
